mc_controller: RTL and testbench

- Multicycle RISC-V control unit that sequences the shared datapath. The datapath has one memory, one ALU, and mux2/mux3 selectors in front of the PC/address, ALU A/B and result buses.
- A Moore main FSM steps each instruction through fetch, decode, execute, memory and writeback. It drives every mux select and write enable.
- A combinational ALU decoder produces the ALU operation.
- Sits beside the datapath in the top-level CPU.

---
 rtl/mc_pkg.sv | 65 ++++++
 rtl/mc_alu_dec.sv | 30 +++
 rtl/mc_controller.sv | 156 +++++++++++++++
 tb/tb_mc_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_JAL,
      S_BEQ,
      S_HALT
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      ALUOP_ADD,
      ALUOP_SUB,
      ALUOP_FUNCT
   } aluop_e;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // Immediate format depends only on the opcode, so it is valid in every state.
   function automatic logic [1:0] imm_src_of(input logic [6:0] op);
      case (op)
         OP_STORE:  return IMM_S;
         OP_BRANCH: return IMM_B;
         OP_JAL:    return IMM_J;
         default:   return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU decoder: ALUOp plus instruction fields to alu_control.
module mc_alu_dec
   import mc_pkg::*;
(
   input  aluop_e      alu_op_i,
   input  logic [2:0]  funct3_i,
   input  logic        funct7b5_i,
   input  logic        op5_i,
   output logic [2:0]  alu_control_o
);

   always_comb begin
      alu_control_o = ALU_ADD;
      case (alu_op_i)
         ALUOP_SUB: alu_control_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3_i)
               // op5 separates R-type sub from addi, which reuses funct7b5 as immediate.
               3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control_o = ALU_SLT;
               3'b110:  alu_control_o = ALU_OR;
               3'b111:  alu_control_o = ALU_AND;
               default: alu_control_o = ALU_ADD;
            endcase
         end
         default: alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control unit: Moore main FSM plus ALU decoder.
// Optional MC_BNE_EN adds bne (funct3=001) to the branch state.
module mc_controller
   import mc_pkg::*;
#(
   parameter bit ILLEGAL_TRAP = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  op,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic        zero,
   output logic        pc_write,
   output logic        adr_src,
   output logic        mem_write,
   output logic        ir_write,
   output logic [1:0]  result_src,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [2:0]  alu_control,
   output logic [1:0]  imm_src,
   output logic        reg_write,
   output logic        illegal_op,
   output logic        halted
);

   state_e state_q, state_d;
   aluop_e alu_op;
   logic   pc_update, branch, take;
   logic   ir_w, mem_w, reg_w, ill;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // NOTE: every signal gets a default first, so no path through the case can infer a latch.
   always_comb begin
      state_d    = state_q;
      pc_update  = 1'b0;
      branch     = 1'b0;
      ir_w       = 1'b0;
      mem_w      = 1'b0;
      reg_w      = 1'b0;
      ill        = 1'b0;
      adr_src    = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RD2;
      alu_op     = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            ir_w       = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            pc_update  = 1'b1;
            state_d    = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_JAL:            state_d = S_JAL;
               OP_BRANCH:         state_d = S_BEQ;
               default: begin
                  ill     = 1'b1;
                  state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_w      = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src = 1'b1;
            mem_w   = 1'b1;
            state_d = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RD1;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_w   = 1'b1;
            state_d = S_FETCH;
         end
         S_JAL: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_update = 1'b1;
            state_d   = S_ALUWB;
         end
         S_BEQ: begin
            alu_src_a = SRCA_RD1;
            alu_op    = ALUOP_SUB;
            branch    = 1'b1;
            state_d   = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

`ifdef MC_BNE_EN
   always_comb begin
      case (funct3)
         3'b000:  take = zero;
         3'b001:  take = ~zero;
         default: take = 1'b0;
      endcase
   end
`else
   assign take = zero;
`endif

   mc_alu_dec u_alu_dec (
      .alu_op_i      (alu_op),
      .funct3_i      (funct3),
      .funct7b5_i    (funct7b5),
      .op5_i         (op[5]),
      .alu_control_o (alu_control)
   );

   // Enables are gated by reset so an interrupted instruction makes no further writes.
   assign pc_write   = ~reset & (pc_update | (branch & take));
   assign ir_write   = ~reset & ir_w;
   assign mem_write  = ~reset & mem_w;
   assign reg_write  = ~reset & reg_w;
   assign illegal_op = ~reset & ill;
   assign halted     = ~reset & (state_q == S_HALT);
   assign imm_src    = imm_src_of(op);

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench: two controllers (ILLEGAL_TRAP=0/1) against a per-instruction step model.
module tb_mc_controller;

   typedef enum int {C_LW, C_SW, C_R, C_I, C_JAL, C_BEQ, C_ILL} cls_e;

   typedef struct {
      cls_e       cls;
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      int         zmode;     // 0 random, 1 force 0, 2 force 1
      int         rst_step;  // step at which reset is asserted, -1 none
      bit         rnd;
   } instr_t;

   typedef struct packed {
      logic       pc_write;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_control;
      logic [1:0] imm_src;
      logic       reg_write;
      logic       illegal_op;
      logic       halted;
   } outs_t;

   logic       clk = 1'b0;
   logic       reset, zero, funct7b5;
   logic [6:0] op;
   logic [2:0] funct3;

   logic       pcw0, adr0, mw0, irw0, rw0, ill0, hlt0;
   logic       pcw1, adr1, mw1, irw1, rw1, ill1, hlt1;
   logic [1:0] res0, sa0, sb0, imm0, res1, sa1, sb1, imm1;
   logic [2:0] alu0, alu1;
   outs_t      o0, o1;

   assign o0 = '{pcw0, adr0, mw0, irw0, res0, sa0, sb0, alu0, imm0, rw0, ill0, hlt0};
   assign o1 = '{pcw1, adr1, mw1, irw1, res1, sa1, sb1, alu1, imm1, rw1, ill1, hlt1};

   always #5 clk = ~clk;

   mc_controller #(.ILLEGAL_TRAP(1'b0)) dut0 (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
      .pc_write(pcw0), .adr_src(adr0), .mem_write(mw0), .ir_write(irw0), .result_src(res0),
      .alu_src_a(sa0), .alu_src_b(sb0), .alu_control(alu0), .imm_src(imm0),
      .reg_write(rw0), .illegal_op(ill0), .halted(hlt0)
   );

   mc_controller #(.ILLEGAL_TRAP(1'b1)) dut1 (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
      .pc_write(pcw1), .adr_src(adr1), .mem_write(mw1), .ir_write(irw1), .result_src(res1),
      .alu_src_a(sa1), .alu_src_b(sb1), .alu_control(alu1), .imm_src(imm1),
      .reg_write(rw1), .illegal_op(ill1), .halted(hlt1)
   );

   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   int     step;
   bit     h1, need_new;
   instr_t cur;
   instr_t dq[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic int len_of(input cls_e c);
      case (c)
         C_LW:    return 5;
         C_BEQ:   return 3;
         C_ILL:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit legal(input logic [6:0] o);
      return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
   endfunction

   function automatic logic [1:0] imm_exp(input logic [6:0] o);
      if (o == 7'b0100011) return 2'd1;
      if (o == 7'b1100011) return 2'd2;
      if (o == 7'b1101111) return 2'd3;
      return 2'd0;
   endfunction

   function automatic logic [2:0] funct_exp(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      case (f3)
         3'd0:    return (o[5] && f7) ? 3'd1 : 3'd0;
         3'd2:    return 3'd5;
         3'd6:    return 3'd3;
         3'd7:    return 3'd2;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic take_exp(input logic [2:0] f3, input logic z);
`ifdef MC_BNE_EN
      if (f3 == 3'd0) return z;
      if (f3 == 3'd1) return !z;
      return 1'b0;
`else
      return z;
`endif
   endfunction

   // Expected outputs for step k of an instruction of a given class.
   function automatic outs_t model(input cls_e c, input int k, input logic [6:0] o,
                                   input logic [2:0] f3, input logic f7, input logic z,
                                   input bit hlt);
      outs_t e = '0;
      e.imm_src = imm_exp(o);
      if (hlt) begin
         e.halted = 1'b1;
         return e;
      end
      if (k == 0) begin
         e.ir_write = 1'b1; e.alu_src_b = 2'd2; e.result_src = 2'd2; e.pc_write = 1'b1;
      end else if (k == 1) begin
         e.alu_src_a = 2'd1; e.alu_src_b = 2'd1; e.illegal_op = (c == C_ILL);
      end else begin
         case (c)
            C_LW: begin
               if (k == 2) begin e.alu_src_a = 2'd2; e.alu_src_b = 2'd1; end
               if (k == 3) e.adr_src = 1'b1;
               if (k == 4) begin e.result_src = 2'd1; e.reg_write = 1'b1; end
            end
            C_SW: begin
               if (k == 2) begin e.alu_src_a = 2'd2; e.alu_src_b = 2'd1; end
               if (k == 3) begin e.adr_src = 1'b1; e.mem_write = 1'b1; end
            end
            C_R, C_I: begin
               if (k == 2) begin
                  e.alu_src_a = 2'd2; e.alu_src_b = (c == C_I) ? 2'd1 : 2'd0;
                  e.alu_control = funct_exp(o, f3, f7);
               end
               if (k == 3) e.reg_write = 1'b1;
            end
            C_JAL: begin
               if (k == 2) begin e.alu_src_a = 2'd1; e.alu_src_b = 2'd2; e.pc_write = 1'b1; end
               if (k == 3) e.reg_write = 1'b1;
            end
            C_BEQ: begin
               e.alu_src_a = 2'd2; e.alu_control = 3'd1; e.pc_write = take_exp(f3, z);
            end
            default: ;
         endcase
      end
      return e;
   endfunction

   function automatic outs_t rmask(input outs_t e);
      outs_t r = e;
      r.pc_write = 1'b0; r.ir_write = 1'b0; r.mem_write = 1'b0;
      r.reg_write = 1'b0; r.illegal_op = 1'b0; r.halted = 1'b0;
      return r;
   endfunction

   function automatic instr_t mk(input cls_e c, input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input int zm, input int rs);
      instr_t t;
      t.cls = c; t.op = o; t.f3 = f3; t.f7 = f7; t.zmode = zm; t.rst_step = rs; t.rnd = 1'b0;
      return t;
   endfunction

   function automatic instr_t rand_instr();
      instr_t t;
      logic [6:0] o;
      cls_e c = cls_e'($urandom_range(0, 6));
      case (c)
         C_LW:    o = 7'b0000011;
         C_SW:    o = 7'b0100011;
         C_R:     o = 7'b0110011;
         C_I:     o = 7'b0010011;
         C_JAL:   o = 7'b1101111;
         C_BEQ:   o = 7'b1100011;
         default: begin
            o = 7'($urandom_range(0, 127));
            while (legal(o)) o = 7'($urandom_range(0, 127));
         end
      endcase
      t = mk(c, o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0, -1);
      t.rnd = 1'b1;
      return t;
   endfunction

   task automatic run_cycle(input logic rst, input logic z);
      outs_t e0, e1;
      reset = rst;
      zero  = z;
      @(negedge clk);
      e0 = model(cur.cls, step, op, funct3, funct7b5, z, 1'b0);
      e1 = model(cur.cls, step, op, funct3, funct7b5, z, h1);
      if (rst) begin
         e0 = rmask(e0);
         e1 = rmask(e1);
      end
      check("nop_mode", 32'(o0), 32'(e0));
      check("trap_mode", 32'(o1), 32'(e1));
      if (rst) begin
         step = 0; h1 = 1'b0; need_new = 1'b1;
      end else begin
         if (cur.cls == C_ILL && step == 1) h1 = 1'b1;
         step++;
         if (step == len_of(cur.cls)) begin
            step = 0; need_new = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      logic z, rst;
      reset = 1'b1; zero = 1'b0; op = 7'b0010011; funct3 = 3'd0; funct7b5 = 1'b0;
      cur = mk(C_I, 7'b0010011, 3'd0, 1'b0, 0, -1);
      step = 0; h1 = 1'b0; need_new = 1'b0;
      @(posedge clk);
      #1;
      run_cycle(1'b1, 1'b0);
      run_cycle(1'b1, 1'b0);

      dq.push_back(mk(C_LW,  7'b0000011, 3'd2, 1'b0, 0, -1));
      dq.push_back(mk(C_R,   7'b0110011, 3'd0, 1'b1, 0, -1));
      dq.push_back(mk(C_I,   7'b0010011, 3'd0, 1'b1, 0, -1));
      dq.push_back(mk(C_BEQ, 7'b1100011, 3'd0, 1'b0, 2, -1));
      dq.push_back(mk(C_BEQ, 7'b1100011, 3'd0, 1'b0, 1, -1));
`ifdef MC_BNE_EN
      dq.push_back(mk(C_BEQ, 7'b1100011, 3'd1, 1'b0, 1, -1));
`endif
      dq.push_back(mk(C_JAL, 7'b1101111, 3'd0, 1'b0, 0, -1));
      dq.push_back(mk(C_SW,  7'b0100011, 3'd2, 1'b0, 0, -1));
      dq.push_back(mk(C_ILL, 7'b1111111, 3'd0, 1'b0, 0, -1));
      dq.push_back(mk(C_R,   7'b0110011, 3'd7, 1'b0, 0, -1));
      dq.push_back(mk(C_I,   7'b0010011, 3'd6, 1'b1, 0, -1));
      dq.push_back(mk(C_LW,  7'b0000011, 3'd2, 1'b0, 0, -1));
      dq.push_back(mk(C_SW,  7'b0100011, 3'd2, 1'b0, 0, -1));
      dq.push_back(mk(C_JAL, 7'b1101111, 3'd0, 1'b0, 0, -1));
      dq.push_back(mk(C_SW,  7'b0100011, 3'd2, 1'b0, 0,  3));

      for (int k = 0; k < 1500; k++) begin
         if (need_new) begin
            cur = (dq.size() > 0) ? dq.pop_front() : rand_instr();
            op = cur.op; funct3 = cur.f3; funct7b5 = cur.f7;
            need_new = 1'b0;
         end
         rst = (step == cur.rst_step) || (cur.rnd && $urandom_range(0, 49) == 0);
         case (cur.zmode)
            1:       z = 1'b0;
            2:       z = 1'b1;
            default: z = 1'($urandom_range(0, 1));
         endcase
         run_cycle(rst, z);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
